// File: rtl/bcd_seq_conv_pkg.sv
// bcd_pkg: shared FSM type, digit width and add-3 digit correction for the sequential BCD converter
package bcd_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
   localparam int BCD_DIGIT_W = 4;
   function automatic logic [BCD_DIGIT_W-1:0] bcd_add3(input logic [BCD_DIGIT_W-1:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction
endpackage

// File: rtl/bcd_seq_conv_if.sv
// bcd_seq_conv_if: start/result bundle of the converter; blank exists only with BCD_BLANK_EN defined
interface bcd_seq_conv_if #(parameter int BIN_W = 14, parameter int DIGITS = 4);
   import bcd_pkg::*;
   logic                            start;
   logic [BIN_W-1:0]                bin;
   logic                            ready;
   logic                            busy;
   logic                            done;
   logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
   logic                            ovf;
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0]               blank;
   modport master (output start, bin, input ready, busy, done, bcd, ovf, blank);
   modport slave  (input start, bin, output ready, busy, done, bcd, ovf, blank);
`else
   modport master (output start, bin, input ready, busy, done, bcd, ovf);
   modport slave  (input start, bin, output ready, busy, done, bcd, ovf);
`endif
endinterface

// File: rtl/bcd_seq_conv_digit_cell.sv
// bcd_digit_cell: one double-dabble digit slice, add-3 correction then shift left with carry in/out
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d,
   input  logic                   cin,
   output logic [BCD_DIGIT_W-1:0] q,
   output logic                   cout
);
   logic [BCD_DIGIT_W-1:0] a;
   assign a    = bcd_add3(d);
   assign q    = {a[BCD_DIGIT_W-2:0], cin};
   assign cout = a[BCD_DIGIT_W-1];
endmodule

// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: one-bit-per-clock binary to BCD converter with overflow flag; BCD_BLANK_EN adds leading-zero mask
module bcd_seq_conv
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic           clk,
   input  logic           reset,
   bcd_seq_conv_if.slave  bus
);
   localparam int CW = $clog2(BIN_W + 1);
   bcd_state_t                    state, state_n;
   logic [CW-1:0]                 cnt;
   logic [BIN_W-1:0]              sr;
   logic [BCD_DIGIT_W*DIGITS-1:0] dig, dig_n;
   logic [DIGITS:0]               ch;
   logic                          sovf;
   logic                          last;
   assign ch[0] = sr[BIN_W-1];
   assign last  = (state == SHIFT) && (cnt == '0);
   genvar k;
   for (k = 0; k < DIGITS; k++) begin : g_cell
      bcd_digit_cell u_cell (
         .d    (dig[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
         .cin  (ch[k]),
         .q    (dig_n[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
         .cout (ch[k+1])
      );
   end
   // State register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_n;
   // Next state: counter holds BIN_W shifts, the extra SHIFT cycle at zero lets the last overflow bit settle
   always_comb begin
      state_n = state;
      state_n = (state == IDLE)  ? (bus.start ? SHIFT : IDLE) :
                (state == SHIFT) ? (cnt == '0 ? DONE : SHIFT) : IDLE;
   end
   // Working datapath: load on accept, correct-and-shift while bits remain
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt  <= '0;
         sr   <= '0;
         dig  <= '0;
         sovf <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         cnt  <= CW'(BIN_W);
         sr   <= bus.bin;
         dig  <= '0;
         sovf <= 1'b0;
      end else if (state == SHIFT && cnt != '0) begin
         cnt  <= cnt - 1'b1;
         sr   <= sr << 1;
         dig  <= dig_n;
         sovf <= sovf | ch[DIGITS];
      end
   // Registered outputs; results load on the edge that enters DONE
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bus.ready <= 1'b1;
         bus.busy  <= 1'b0;
         bus.done  <= 1'b0;
         bus.bcd   <= '0;
         bus.ovf   <= 1'b0;
      end else begin
         bus.ready <= state_n == IDLE;
         bus.busy  <= state_n == SHIFT;
         bus.done  <= state_n == DONE;
         if (last) begin
            bus.bcd <= sovf ? {DIGITS{4'd9}} : dig;
            bus.ovf <= sovf;
         end
      end
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] blank_n;
   logic              z;
   // Leading-zero mask: digit k blanks when it and every higher digit are zero; digit 0 never blanks
   always_comb begin
      blank_n = '0;
      z       = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         z          = z & (dig[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
         blank_n[i] = z;
      end
   end
   // Mask register loads with bcd and is cleared on overflow
   always_ff @(posedge clk or posedge reset)
      if (reset)     bus.blank <= ~DIGITS'(1);
      else if (last) bus.blank <= sovf ? '0 : blank_n;
`endif
endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb_bcd_seq_conv: scoreboard bench for bcd_seq_conv at (14,4), (14,5) and (1,1); checks blank when BCD_BLANK_EN is defined
module tb_bcd_seq_conv;
   typedef struct {int u; logic [19:0] b; logic o; logic [4:0] bl; int acc;} exp_t;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  st = '0;
   logic [13:0] bn [3];
   logic [2:0]  rdy, bsy, dn, ov;
   logic [19:0] bc [3];
   logic [4:0]  bl [3];
   int          cyc = 0;
   int          nchk = 0;
   int          nerr = 0;
   exp_t        sb [$];
   int          lat [3] = '{16, 16, 3};

   bcd_seq_conv_if #(.BIN_W(14), .DIGITS(4)) b0 ();
   bcd_seq_conv_if #(.BIN_W(14), .DIGITS(5)) b1 ();
   bcd_seq_conv_if #(.BIN_W(1),  .DIGITS(1)) b2 ();
   bcd_seq_conv #(.BIN_W(14), .DIGITS(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
   bcd_seq_conv #(.BIN_W(14), .DIGITS(5)) u1 (.clk(clk), .reset(reset), .bus(b1));
   bcd_seq_conv #(.BIN_W(1),  .DIGITS(1)) u2 (.clk(clk), .reset(reset), .bus(b2));

   assign b0.start = st[0];
   assign b1.start = st[1];
   assign b2.start = st[2];
   assign b0.bin   = bn[0];
   assign b1.bin   = bn[1];
   assign b2.bin   = bn[2][0:0];
   assign rdy = {b2.ready, b1.ready, b0.ready};
   assign bsy = {b2.busy, b1.busy, b0.busy};
   assign dn  = {b2.done, b1.done, b0.done};
   assign ov  = {b2.ovf, b1.ovf, b0.ovf};
   assign bc[0] = 20'(b0.bcd);
   assign bc[1] = 20'(b1.bcd);
   assign bc[2] = 20'(b2.bcd);
`ifdef BCD_BLANK_EN
   assign bl[0] = 5'(b0.blank);
   assign bl[1] = 5'(b1.blank);
   assign bl[2] = 5'(b2.blank);
`else
   assign bl[0] = '0;
   assign bl[1] = '0;
   assign bl[2] = '0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s unit=%0d got=%0h expected=%0h", nm, u, act, exp);
      end
   endtask

   task automatic go(input int u, input int val, input logic [19:0] eb, input logic eo,
                     input logic [4:0] ebl, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (rdy[u] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (rdy[u] !== 1'b1) begin
         chk("ready_timeout", u, 32'(rdy[u]), 1);
         return;
      end
      st[u] = 1'b1;
      bn[u] = 14'(val);
      @(posedge clk);
      if (push) sb.push_back('{u, eb, eo, ebl, cyc});
      @(negedge clk);
      st[u] = 1'b0;
      bn[u] = ~bn[u];
   endtask

   always @(negedge clk)
      for (int u = 0; u < 3; u++)
         if (dn[u] === 1'b1) begin
            int   idx;
            exp_t e;
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].u == u) idx = i;
            if (idx < 0) begin
               nchk++;
               nerr++;
               $display("FAIL unexpected_done unit=%0d got bcd=%0h expected no done", u, bc[u]);
            end else begin
               e = sb[idx];
               sb.delete(idx);
               chk("bcd", u, 32'(bc[u]), 32'(e.b));
               chk("ovf", u, 32'(ov[u]), 32'(e.o));
               chk("latency", u, cyc - e.acc, lat[u]);
`ifdef BCD_BLANK_EN
               chk("blank", u, 32'(bl[u]), 32'(e.bl));
`endif
            end
         end

   initial begin
      int n;
      for (int i = 0; i < 3; i++) bn[i] = '0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 3; u++) begin
         chk("rst_ready", u, 32'(rdy[u]), 1);
         chk("rst_busy", u, 32'(bsy[u]), 0);
         chk("rst_done", u, 32'(dn[u]), 0);
         chk("rst_bcd", u, 32'(bc[u]), 0);
         chk("rst_ovf", u, 32'(ov[u]), 0);
      end
`ifdef BCD_BLANK_EN
      chk("rst_blank", 0, 32'(bl[0]), 32'b1110);
      chk("rst_blank", 1, 32'(bl[1]), 32'b11110);
      chk("rst_blank", 2, 32'(bl[2]), 32'b0);
`endif
      reset = 1'b0;
      go(0, 9999,  20'h09999, 1'b0, 5'b00000, 1'b1);
      go(0, 0,     20'h00000, 1'b0, 5'b01110, 1'b1);
      go(0, 16383, 20'h09999, 1'b1, 5'b00000, 1'b1);
      go(1, 16383, 20'h16383, 1'b0, 5'b00000, 1'b1);
      go(1, 0,     20'h00000, 1'b0, 5'b11110, 1'b1);
      go(2, 1,     20'h00001, 1'b0, 5'b00000, 1'b1);
      go(2, 0,     20'h00000, 1'b0, 5'b00000, 1'b1);
      go(0, 1234,  20'h01234, 1'b0, 5'b00000, 1'b1);
      repeat (3) @(negedge clk);
      chk("busy_during_shift", 0, 32'(bsy[0]), 1);
      st[0] = 1'b1;
      bn[0] = 14'd5678;
      @(negedge clk);
      st[0] = 1'b0;
      go(0, 5678,  20'h05678, 1'b0, 5'b00000, 1'b1);
      go(0, 4321,  20'h00000, 1'b0, 5'b00000, 1'b0);
      repeat (7) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_bcd", 0, 32'(bc[0]), 0);
      chk("abort_ready", 0, 32'(rdy[0]), 1);
      chk("abort_done", 0, 32'(dn[0]), 0);
      @(negedge clk);
      reset = 1'b0;
      go(0, 42,    20'h00042, 1'b0, 5'b01100, 1'b1);
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("pending_results", 0, 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end
endmodule
